// File: rtl/led.sv
// RGB status-LED sequencer.
// A prescaler produces a tick every CLK_DIV clocks. Each tick advances a 3-bit
// colour step through off, B, G, GB, R, RB, RG, RGB. The colour is mapped to
// registered pins with selectable drive polarity (ACTIVE_LOW).
// Optional build macro LED_PWM_EN adds a free-running PWM counter that gates
// each lit colour to DUTY out of every 2**PWM_BITS clocks.
module led #(
    parameter int CLK_DIV    = 4,
    parameter int ACTIVE_LOW = 0,
    parameter int PWM_BITS   = 4,
    parameter int DUTY       = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_led_r,
    output logic o_led_g,
    output logic o_led_b
);

    localparam int              PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic            POL      = (ACTIVE_LOW != 0);

    // Reject parameter values the datapath cannot represent.
    if (CLK_DIV < 1 || PWM_BITS < 1 || DUTY < 0) begin : g_param_check
        $error("led: illegal parameter value");
    end

    // Colour steps; the encoding is the {r,g,b} lit pattern.
    typedef enum logic [2:0] {
        STEP_OFF = 3'd0,
        STEP_B   = 3'd1,
        STEP_G   = 3'd2,
        STEP_GB  = 3'd3,
        STEP_R   = 3'd4,
        STEP_RB  = 3'd5,
        STEP_RG  = 3'd6,
        STEP_RGB = 3'd7
    } step_t;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             tick;
    step_t            step_q;
    step_t            step_d;
    logic [2:0]       step_bits;
    logic             pwm_on;
    logic [2:0]       pins_d;

    // Prescaler next value and tick decode.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Step sequencing: advance one colour per tick, wrapping RGB back to off.
    always_comb begin
        step_d = step_q;
        if (tick) begin
            unique case (step_q)
                STEP_OFF: step_d = STEP_B;
                STEP_B:   step_d = STEP_G;
                STEP_G:   step_d = STEP_GB;
                STEP_GB:  step_d = STEP_R;
                STEP_R:   step_d = STEP_RB;
                STEP_RB:  step_d = STEP_RG;
                STEP_RG:  step_d = STEP_RGB;
                STEP_RGB: step_d = STEP_OFF;
                default:  step_d = STEP_OFF;
            endcase
        end
    end

    // Step state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            step_q <= STEP_OFF;
        end else begin
            step_q <= step_d;
        end
    end

`ifdef LED_PWM_EN
    localparam logic [31:0] DUTY_U = 32'(DUTY);

    logic [PWM_BITS-1:0] pwm_q;

    // Free-running PWM counter; independent of prescaler and step timing.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_BITS'(1);
        end
    end

    // Lit window: first DUTY counts of each PWM period (all counts if DUTY covers the period).
    always_comb begin
        pwm_on = (32'(pwm_q) < DUTY_U);
    end
`else
    // Without PWM every set colour bit is steadily lit.
    always_comb begin
        pwm_on = 1'b1;
    end
`endif

    // Colour map {r,g,b} = step bits, gated by PWM, then drive polarity applied.
    always_comb begin
        step_bits = step_q;
        pins_d    = (step_bits & {3{pwm_on}}) ^ {3{POL}};
    end

    // Pin registers; reset drives the unlit level.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_led_r <= POL;
            o_led_g <= POL;
            o_led_b <= POL;
        end else begin
            o_led_r <= pins_d[2];
            o_led_g <= pins_d[1];
            o_led_b <= pins_d[0];
        end
    end

endmodule

// File: tb/tb_led.sv
// Directed self-checking bench for the RGB LED sequencer.
module tb_led;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic r0, g0, b0;
    logic r1, g1, b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // CLK_DIV=4, active-high pins. DUTY=16 keeps it steady if PWM is built in.
    led #(.CLK_DIV(4), .ACTIVE_LOW(0), .PWM_BITS(4), .DUTY(16)) dut0 (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_led_r(r0),
        .o_led_g(g0),
        .o_led_b(b0)
    );

    // CLK_DIV=1, active-low pins.
    led #(.CLK_DIV(1), .ACTIVE_LOW(1), .PWM_BITS(4), .DUTY(16)) dut1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_led_r(r1),
        .o_led_g(g1),
        .o_led_b(b1)
    );

`ifdef LED_PWM_EN
    logic r2, g2, b2;
    logic r3, g3, b3;

    led #(.CLK_DIV(64), .ACTIVE_LOW(0), .PWM_BITS(4), .DUTY(8)) dut2 (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_led_r(r2),
        .o_led_g(g2),
        .o_led_b(b2)
    );

    led #(.CLK_DIV(64), .ACTIVE_LOW(0), .PWM_BITS(4), .DUTY(0)) dut3 (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_led_r(r3),
        .o_led_g(g3),
        .o_led_b(b3)
    );
`endif

    // Expected {r,g,b} for dut0 after edge n (n >= 1) since reset release.
    function automatic logic [2:0] exp0(input int n);
        int s;
        s = ((n - 1) / 4) % 8;
        return {s[2], s[1], s[0]};
    endfunction

    // Expected {r,g,b} pin levels for dut1 after edge n (inverted map, one step per clock).
    function automatic logic [2:0] exp1(input int n);
        int s;
        s = (n - 1) % 8;
        return ~{s[2], s[1], s[0]};
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        total++;
        if ({r0, g0, b0} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pre_edge_dut0 got=%b exp=%b", {r0, g0, b0}, 3'b000);
        end
        total++;
        if ({r1, g1, b1} !== 3'b111) begin
            bad++;
            $display("FAIL reset_pre_edge_dut1 got=%b exp=%b", {r1, g1, b1}, 3'b111);
        end
        for (int i = 0; i < 10; i++) begin
            edge_sample();
            total++;
            if ({r0, g0, b0} !== 3'b000) begin
                bad++;
                $display("FAIL reset_hold_dut0 cyc=%0d got=%b exp=%b", i, {r0, g0, b0}, 3'b000);
            end
            total++;
            if ({r1, g1, b1} !== 3'b111) begin
                bad++;
                $display("FAIL reset_hold_dut1 cyc=%0d got=%b exp=%b", i, {r1, g1, b1}, 3'b111);
            end
        end
    endtask

    task automatic test_sequence();
        release_reset();
        for (int n = 1; n <= 32; n++) begin
            edge_sample();
            total++;
            if ({r0, g0, b0} !== exp0(n)) begin
                bad++;
                $display("FAIL seq_dut0 edge=%0d got=%b exp=%b", n, {r0, g0, b0}, exp0(n));
            end
            total++;
            if ({r1, g1, b1} !== exp1(n)) begin
                bad++;
                $display("FAIL seq_dut1 edge=%0d got=%b exp=%b", n, {r1, g1, b1}, exp1(n));
            end
            if (n == 4) begin
                total++;
                if (b0 !== 1'b0) begin
                    bad++;
                    $display("FAIL first_blue_early edge=4 got=%b exp=0", b0);
                end
            end
            if (n == 5) begin
                total++;
                if (b0 !== 1'b1) begin
                    bad++;
                    $display("FAIL first_blue edge=5 got=%b exp=1", b0);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int n = 33; n <= 118; n++) begin
            edge_sample();
            total++;
            if ({r0, g0, b0} !== exp0(n)) begin
                bad++;
                $display("FAIL wrap_dut0 edge=%0d got=%b exp=%b", n, {r0, g0, b0}, exp0(n));
            end
            total++;
            if ({r1, g1, b1} !== exp1(n)) begin
                bad++;
                $display("FAIL wrap_dut1 edge=%0d got=%b exp=%b", n, {r1, g1, b1}, exp1(n));
            end
            if (n == 33) begin
                total++;
                if ({r0, g0, b0} !== 3'b000) begin
                    bad++;
                    $display("FAIL wrap_all_off edge=33 got=%b exp=000", {r0, g0, b0});
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        // Edge 118: dut0 shows step 5 (R+B) with prescaler at 2.
        total++;
        if ({r0, g0, b0} !== 3'b101) begin
            bad++;
            $display("FAIL mid_reset_setup got=%b exp=101", {r0, g0, b0});
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({r0, g0, b0} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset_dut0 got=%b exp=000", {r0, g0, b0});
        end
        total++;
        if ({r1, g1, b1} !== 3'b111) begin
            bad++;
            $display("FAIL async_reset_dut1 got=%b exp=111", {r1, g1, b1});
        end
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            total++;
            if ({r0, g0, b0} !== 3'b000) begin
                bad++;
                $display("FAIL mid_reset_hold cyc=%0d got=%b exp=000", i, {r0, g0, b0});
            end
        end
        release_reset();
        for (int n = 1; n <= 12; n++) begin
            edge_sample();
            total++;
            if ({r0, g0, b0} !== exp0(n)) begin
                bad++;
                $display("FAIL restart_dut0 edge=%0d got=%b exp=%b", n, {r0, g0, b0}, exp0(n));
            end
            total++;
            if ({r1, g1, b1} !== exp1(n)) begin
                bad++;
                $display("FAIL restart_dut1 edge=%0d got=%b exp=%b", n, {r1, g1, b1}, exp1(n));
            end
        end
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        int         s;
        logic [2:0] e;
        int         cnt_r;
        int         cnt_g;
        int         cnt_b;
        cnt_r = 0;
        cnt_g = 0;
        cnt_b = 0;
        #1 rst = 1'b0;
        edge_sample();
        release_reset();
        for (int n = 1; n <= 480; n++) begin
            edge_sample();
            s = ((n - 1) / 64) % 8;
            e = (((n - 1) % 16) < 8) ? {s[2], s[1], s[0]} : 3'b000;
            total++;
            if ({r2, g2, b2} !== e) begin
                bad++;
                $display("FAIL pwm_duty8 edge=%0d got=%b exp=%b", n, {r2, g2, b2}, e);
            end
            total++;
            if ({r3, g3, b3} !== 3'b000) begin
                bad++;
                $display("FAIL pwm_duty0 edge=%0d got=%b exp=000", n, {r3, g3, b3});
            end
            if (n >= 449 && n <= 464) begin
                cnt_r += int'(r2);
                cnt_g += int'(g2);
                cnt_b += int'(b2);
            end
        end
        total++;
        if (cnt_r != 8 || cnt_g != 8 || cnt_b != 8) begin
            bad++;
            $display("FAIL pwm_lit_count got=%0d/%0d/%0d exp=8/8/8", cnt_r, cnt_g, cnt_b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_mid_reset();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
